// File: rtl/dst_mem_pkg.sv
// Shared constants and types for the destination-operand memory writer.
package dst_mem_pkg;
    localparam int DATA_W = 8;
    localparam int ADDR_W = 3;
    localparam int DEPTH  = 8;
    localparam int CNT_W  = 4;

    typedef logic [ADDR_W-1:0] addr_t;
    typedef logic [DATA_W-1:0] data_t;
    typedef logic [CNT_W-1:0]  cnt_t;

    typedef enum logic {
        ST_IDLE,
        ST_CLEAR
    } state_e;

    localparam cnt_t  CNT_MAX  = '1;
    localparam addr_t LAST_IDX = addr_t'(DEPTH - 1);
endpackage

// File: rtl/dst_mem_array.sv
// DEPTH x DATA_W storage: one synchronous write port, one registered read port (1-cycle latency).
// Read-before-write on a same-address collision; storage itself is never reset.
module dst_mem_array
    import dst_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              we_i,
    input  logic [ADDR_W-1:0] waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [ADDR_W-1:0] raddr_i,
    output logic [DATA_W-1:0] rdata_o
);
    data_t mem_q [DEPTH];
    data_t rdata_q;

    always_ff @(posedge clk) begin
        if (we_i) begin
            mem_q[waddr_i] <= wdata_i;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            rdata_q <= '0;
        end else begin
            rdata_q <= mem_q[raddr_i];
        end
    end

    assign rdata_o = rdata_q;
endmodule

// File: rtl/dst_memory_writer.sv
// Destination memory writer: valid/ready write port, 1-cycle read port, 8-cycle clear sweep after reset/clear_req.
// wr_ready is low during reset, during a sweep and whenever clear_req is high; DST_MEMORY_WRITER_BYPASS_EN adds write-through reads.
module dst_memory_writer
    import dst_mem_pkg::*;
(
    input  logic              clk,
    input  logic              rst,
    input  logic              wr_valid,
    output logic              wr_ready,
    input  logic [ADDR_W-1:0] wr_addr,
    input  logic [DATA_W-1:0] wr_data,
    input  logic              clear_req,
    output logic              clear_done,
    output logic              busy,
    output logic [CNT_W-1:0]  wr_count,
    input  logic [ADDR_W-1:0] rd_addr,
    output logic [DATA_W-1:0] rd_value
);
    state_e state_q, state_d;
    addr_t  clr_idx_q, clr_idx_d;
    cnt_t   cnt_q, cnt_d;
    logic   done_q, done_d;

    logic   wr_acc;
    logic   arr_we;
    addr_t  arr_waddr;
    data_t  arr_wdata;
    data_t  arr_rdata;

    always_comb begin
        state_d   = state_q;
        clr_idx_d = clr_idx_q;
        cnt_d     = cnt_q;
        done_d    = 1'b0;
        wr_ready  = (state_q == ST_IDLE) && !clear_req && !rst;
        wr_acc    = wr_valid && wr_ready;
        arr_we    = 1'b0;
        arr_waddr = wr_addr;
        arr_wdata = wr_data;

        case (state_q)
            ST_CLEAR: begin
                // The sweep shares the array write port; reset suppresses it.
                arr_we    = !rst;
                arr_waddr = clr_idx_q;
                arr_wdata = '0;
                clr_idx_d = clr_idx_q + 1'b1;
                if (clr_idx_q == LAST_IDX) begin
                    state_d = ST_IDLE;
                    done_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            ST_IDLE: begin
                clr_idx_d = '0;
                if (clear_req) begin
                    state_d = ST_CLEAR;
                end else if (wr_acc) begin
                    arr_we = 1'b1;
                    if (cnt_q != CNT_MAX) begin
                        cnt_d = cnt_q + 1'b1;
                    end
                end
            end
            default: begin
                state_d = ST_CLEAR;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= ST_CLEAR;
            clr_idx_q <= '0;
            cnt_q     <= '0;
            done_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            clr_idx_q <= clr_idx_d;
            cnt_q     <= cnt_d;
            done_q    <= done_d;
        end
    end

    assign busy       = (state_q == ST_CLEAR) || rst;
    assign clear_done = done_q;
    assign wr_count   = cnt_q;

    dst_mem_array u_array (
        .clk     (clk),
        .rst     (rst),
        .we_i    (arr_we),
        .waddr_i (arr_waddr),
        .wdata_i (arr_wdata),
        .raddr_i (rd_addr),
        .rdata_o (arr_rdata)
    );

`ifdef DST_MEMORY_WRITER_BYPASS_EN
    logic  byp_q;
    data_t byp_dat_q;

    // Forward any array write (including sweep zeros) that hits the address being read.
    always_ff @(posedge clk) begin
        if (rst) begin
            byp_q     <= 1'b0;
            byp_dat_q <= '0;
        end else begin
            byp_q     <= arr_we && (arr_waddr == rd_addr);
            byp_dat_q <= arr_wdata;
        end
    end

    assign rd_value = byp_q ? byp_dat_q : arr_rdata;
`else
    assign rd_value = arr_rdata;
`endif
endmodule
